// File: rtl/div.sv
// Multi-cycle 32-bit radix-2 restoring divider for the execute stage.
// Returns {remainder, quotient} with RISC-V divide-by-zero and overflow semantics.
module div (
   input  logic        clk,
   input  logic        rst,
   input  logic        signed_div_i,
   input  logic [31:0] opdata1_i,
   input  logic [31:0] opdata2_i,
   input  logic        start_i,
   input  logic        annul_i,
   output logic [63:0] result_o,
   output logic        ready_o
);

   typedef enum logic [1:0] {
      ST_FREE   = 2'd0,
      ST_BYZERO = 2'd1,
      ST_ON     = 2'd2,
      ST_END    = 2'd3
   } state_t;

   state_t      r_state;
   logic [4:0]  r_cnt;
   logic [31:0] r_dividendOrig;
   logic [31:0] r_divisor;
   logic [32:0] r_rem;
   logic [31:0] r_quo;
   logic        r_qneg;
   logic        r_rneg;

   logic [31:0] w_absOp1;
   logic [31:0] w_absOp2;
   logic [33:0] w_remShift;
   logic [33:0] w_diff;
   logic        w_geq;
   logic [32:0] w_remNext;
   logic [31:0] w_quoNext;
   logic [31:0] w_quoFinal;
   logic [31:0] w_remFinal;

   // 0x80000000 negates to itself and is then treated as unsigned 2^31.
   assign w_absOp1 = (signed_div_i && opdata1_i[31]) ? (~opdata1_i + 32'd1) : opdata1_i;
   assign w_absOp2 = (signed_div_i && opdata2_i[31]) ? (~opdata2_i + 32'd1) : opdata2_i;

   assign w_remShift = {r_rem, r_quo[31]};
   assign w_diff     = w_remShift - {2'b00, r_divisor};
   assign w_geq      = ~w_diff[33];
   assign w_remNext  = w_geq ? w_diff[32:0] : w_remShift[32:0];
   assign w_quoNext  = {r_quo[30:0], w_geq};
   assign w_quoFinal = r_qneg ? (~w_quoNext + 32'd1) : w_quoNext;
   assign w_remFinal = r_rneg ? (~w_remNext[31:0] + 32'd1) : w_remNext[31:0];

   // Annul returns to FREE from any state and discards whatever was in flight.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state        <= ST_FREE;
         r_cnt          <= 5'd0;
         r_dividendOrig <= 32'd0;
         r_divisor      <= 32'd0;
         r_rem          <= 33'd0;
         r_quo          <= 32'd0;
         r_qneg         <= 1'b0;
         r_rneg         <= 1'b0;
         result_o       <= 64'd0;
         ready_o        <= 1'b0;
      end else if (annul_i) begin
         r_state  <= ST_FREE;
         result_o <= 64'd0;
         ready_o  <= 1'b0;
      end else begin
         case (r_state)
            ST_FREE: begin
               result_o <= 64'd0;
               ready_o  <= 1'b0;
               if (start_i) begin
                  r_dividendOrig <= opdata1_i;
                  r_divisor      <= w_absOp2;
                  r_quo          <= w_absOp1;
                  r_rem          <= 33'd0;
                  r_cnt          <= 5'd0;
                  r_qneg         <= signed_div_i & (opdata1_i[31] ^ opdata2_i[31]);
                  r_rneg         <= signed_div_i & opdata1_i[31];
                  r_state        <= (opdata2_i == 32'd0) ? ST_BYZERO : ST_ON;
               end
            end
            ST_BYZERO: begin
               result_o <= {r_dividendOrig, 32'hFFFF_FFFF};
               ready_o  <= 1'b1;
               r_state  <= ST_END;
            end
            ST_ON: begin
               r_rem <= w_remNext;
               r_quo <= w_quoNext;
               r_cnt <= r_cnt + 5'd1;
               if (r_cnt == 5'd31) begin
                  result_o <= {w_remFinal, w_quoFinal};
                  ready_o  <= 1'b1;
                  r_state  <= ST_END;
               end
            end
            ST_END: begin
               if (!start_i) begin
                  result_o <= 64'd0;
                  ready_o  <= 1'b0;
                  r_state  <= ST_FREE;
               end
            end
            default: begin
               r_state <= ST_FREE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_div.sv
// Self-checking bench for div: table of directed divides plus hand-written
// sequences for annul, reset, start/annul overlap and operand changes.
module tb_div;

   logic        clk = 1'b0;
   logic        rst;
   logic        signedDiv;
   logic [31:0] op1;
   logic [31:0] op2;
   logic        startReq;
   logic        annulReq;
   logic [63:0] resultO;
   logic        readyO;

   int numChecks = 0;
   int numFails  = 0;

   typedef struct {
      string       name;
      logic        isSigned;
      logic [31:0] dividend;
      logic [31:0] divisor;
      logic [63:0] expResult;
      int          expLatency;
   } vector_t;

   vector_t vectors[10];

   div dut (
      .clk          (clk),
      .rst          (rst),
      .signed_div_i (signedDiv),
      .opdata1_i    (op1),
      .opdata2_i    (op2),
      .start_i      (startReq),
      .annul_i      (annulReq),
      .result_o     (resultO),
      .ready_o      (readyO)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
      numChecks++;
      if (actual !== expected) begin
         numFails++;
         $display("[TB] FAIL %s: got 0x%016h, expected 0x%016h", name, actual, expected);
      end
   endtask

   // Drives a request on a falling edge so the next rising edge is E0.
   task automatic applyStimulus(input logic s, input logic [31:0] a, input logic [31:0] b);
      @(negedge clk);
      signedDiv = s;
      op1       = a;
      op2       = b;
      startReq  = 1'b1;
   endtask

   // Counts falling edges until ready; lat=33 means ready became visible after E32.
   task automatic waitReady(input int maxCycles, output int lat);
      lat = 0;
      while (lat < maxCycles) begin
         @(negedge clk);
         lat++;
         if (readyO) break;
      end
      if (!readyO) lat = -1;
   endtask

   task automatic watchNoReady(input int cycles, output int seen);
      seen = 0;
      for (int i = 0; i < cycles; i++) begin
         @(negedge clk);
         if (readyO) seen++;
      end
   endtask

   task automatic releaseAndCheck(input string name);
      startReq = 1'b0;
      @(negedge clk);
      checkOutput({name, " ready after release"}, 64'(readyO), 64'd0);
      checkOutput({name, " result after release"}, resultO, 64'd0);
   endtask

   initial begin
      int lat;
      int seen;

      vectors[0] = '{"u 100/7",           1'b0, 32'd100,       32'd7,         64'h00000002_0000000E, 33};
      vectors[1] = '{"s -100/7",          1'b1, 32'hFFFFFF9C,  32'd7,         64'hFFFFFFFE_FFFFFFF2, 33};
      vectors[2] = '{"s 7/-2",            1'b1, 32'd7,         32'hFFFFFFFE,  64'h00000001_FFFFFFFD, 33};
      vectors[3] = '{"s min/0",           1'b1, 32'h80000000,  32'd0,         64'h80000000_FFFFFFFF, 2};
      vectors[4] = '{"u 5/0",             1'b0, 32'd5,         32'd0,         64'h00000005_FFFFFFFF, 2};
      vectors[5] = '{"s overflow",        1'b1, 32'h80000000,  32'hFFFFFFFF,  64'h00000000_80000000, 33};
      vectors[6] = '{"u max/max",         1'b0, 32'hFFFFFFFF,  32'hFFFFFFFF,  64'h00000000_00000001, 33};
      vectors[7] = '{"s -7/-2",           1'b1, 32'hFFFFFFF9,  32'hFFFFFFFE,  64'hFFFFFFFF_00000003, 33};
      vectors[8] = '{"s min/7",           1'b1, 32'h80000000,  32'd7,         64'hFFFFFFFE_EDB6DB6E, 33};
      vectors[9] = '{"u 0x80000000/7",    1'b0, 32'h80000000,  32'd7,         64'h00000002_12492492, 33};

      rst       = 1'b1;
      signedDiv = 1'b0;
      op1       = 32'd0;
      op2       = 32'd0;
      startReq  = 1'b0;
      annulReq  = 1'b0;
      repeat (2) @(negedge clk);
      checkOutput("reset ready", 64'(readyO), 64'd0);
      checkOutput("reset result", resultO, 64'd0);
      rst = 1'b0;
      @(negedge clk);
      checkOutput("idle ready", 64'(readyO), 64'd0);

      for (int v = 0; v < 10; v++) begin
         applyStimulus(vectors[v].isSigned, vectors[v].dividend, vectors[v].divisor);
         waitReady(40, lat);
         checkOutput({vectors[v].name, " latency"}, 64'(lat), 64'(vectors[v].expLatency));
         checkOutput({vectors[v].name, " result"}, resultO, vectors[v].expResult);
         releaseAndCheck(vectors[v].name);
      end

      // Annul mid-divide: ready must never rise, and the next request runs cleanly.
      applyStimulus(1'b0, 32'd100, 32'd7);
      repeat (10) @(negedge clk);
      annulReq = 1'b1;
      startReq = 1'b0;
      @(negedge clk);
      annulReq = 1'b0;
      checkOutput("annul ready", 64'(readyO), 64'd0);
      watchNoReady(40, seen);
      checkOutput("annul no ready", 64'(seen), 64'd0);
      applyStimulus(1'b0, 32'd9, 32'd3);
      waitReady(40, lat);
      checkOutput("after annul latency", 64'(lat), 64'd33);
      checkOutput("after annul result", resultO, 64'h00000000_00000003);
      releaseAndCheck("after annul");

      // Annul on the completion edge: FREE wins.
      applyStimulus(1'b0, 32'd100, 32'd7);
      repeat (32) @(negedge clk);
      annulReq = 1'b1;
      startReq = 1'b0;
      @(negedge clk);
      annulReq = 1'b0;
      checkOutput("annul at E32 ready", 64'(readyO), 64'd0);
      watchNoReady(5, seen);
      checkOutput("annul at E32 stays low", 64'(seen), 64'd0);

      // Annul while in BYZERO.
      applyStimulus(1'b0, 32'd5, 32'd0);
      @(negedge clk);
      annulReq = 1'b1;
      startReq = 1'b0;
      @(negedge clk);
      annulReq = 1'b0;
      watchNoReady(5, seen);
      checkOutput("annul byzero", 64'(seen), 64'd0);

      // Start together with annul is not accepted; acceptance begins when annul drops.
      @(negedge clk);
      signedDiv = 1'b0;
      op1       = 32'd100;
      op2       = 32'd7;
      startReq  = 1'b1;
      annulReq  = 1'b1;
      repeat (3) @(negedge clk);
      annulReq = 1'b0;
      waitReady(40, lat);
      checkOutput("start+annul latency", 64'(lat), 64'd33);
      checkOutput("start+annul result", resultO, 64'h00000002_0000000E);
      releaseAndCheck("start+annul");

      // Operands change after acceptance; ready stays high while start is held.
      applyStimulus(1'b1, 32'hFFFFFF9C, 32'd7);
      @(negedge clk);
      signedDiv = 1'b0;
      op1       = 32'd5;
      op2       = 32'd0;
      waitReady(40, lat);
      checkOutput("opchange latency", 64'(lat + 1), 64'd33);
      checkOutput("opchange result", resultO, 64'hFFFFFFFE_FFFFFFF2);
      repeat (3) @(negedge clk);
      checkOutput("held ready", 64'(readyO), 64'd1);
      checkOutput("held result", resultO, 64'hFFFFFFFE_FFFFFFF2);
      releaseAndCheck("held");

      // Reset mid-divide and with a result on the outputs.
      applyStimulus(1'b0, 32'd100, 32'd7);
      repeat (6) @(negedge clk);
      rst = 1'b1;
      #1;
      checkOutput("rst mid-ON ready", 64'(readyO), 64'd0);
      checkOutput("rst mid-ON result", resultO, 64'd0);
      startReq = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      applyStimulus(1'b0, 32'd100, 32'd7);
      waitReady(40, lat);
      checkOutput("pre-rst END result", resultO, 64'h00000002_0000000E);
      #2;
      rst = 1'b1;
      #1;
      checkOutput("rst in END ready", 64'(readyO), 64'd0);
      checkOutput("rst in END result", resultO, 64'd0);
      startReq = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      applyStimulus(1'b0, 32'd9, 32'd3);
      waitReady(40, lat);
      checkOutput("after rst latency", 64'(lat), 64'd33);
      checkOutput("after rst result", resultO, 64'h00000000_00000003);
      releaseAndCheck("after rst");

      $display("End of test - %0d assertions evaluated, %0d failures", numChecks, numFails);
      $finish;
   end

endmodule
